// File: rtl/bullet_target_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bullet_target_pkg
// Brief    : Shared game constants and target state encoding
// Revision : 1.0 - initial release
// ============================================================================
package bullet_target_pkg;

  localparam int H_ACTIVE = 1024;
  localparam int V_ACTIVE = 768;
  localparam int COORD_W  = 11;

  typedef enum logic [1:0] {
    ALIVE = 2'd0,
    FLASH = 2'd1,
    DEAD  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/bullet_target_box_overlap.sv
`default_nettype none
// ============================================================================
// Module   : bullet_target_box_overlap
// Brief    : Combinational 12-bit half-open AABB overlap test (box A vs box B)
// Revision : 1.0 - initial release
// ============================================================================
module bullet_target_box_overlap #(
  parameter int A_W = 1,
  parameter int A_H = 1,
  parameter int B_W = 1,
  parameter int B_H = 1
) (
  input  logic [11:0] ax,
  input  logic [11:0] ay,
  input  logic [11:0] bx,
  input  logic [11:0] by,
  output logic        overlap
);

  // 12-bit sums leave headroom above the 11-bit coordinates, so no wrap.
  assign overlap = (ax < bx + 12'(B_W)) && (ax + 12'(A_W) > bx) &&
                   (ay < by + 12'(B_H)) && (ay + 12'(A_H) > by);

endmodule
`default_nettype wire

// File: rtl/bullet_target.sv
`default_nettype none
// ============================================================================
// Module   : bullet_target
// Brief    : Patrolling target sprite: collision, hit points, flash, death,
//            respawn and registered pixel enable
// Revision : 1.0 - initial release
// ============================================================================
module bullet_target
  import bullet_target_pkg::*;
#(
  parameter logic [10:0] TX            = 11'd800,
  parameter int          TW            = 16,
  parameter int          TH            = 32,
  parameter int          BW            = 4,
  parameter logic [10:0] Y_MIN         = 11'd40,
  parameter logic [10:0] Y_MAX         = 11'd440,
  parameter int          STEP          = 2,
  parameter int          HP            = 3,
  parameter int          FLASH_TICKS   = 8,
  parameter int          RESPAWN_TICKS = 60
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] bx,
  input  logic [COORD_W-1:0] by,
  input  logic               bvalid,
  input  logic               timer,
  output logic               target,
  output logic               hit,
  output logic [2:0]         hp_left,
  output logic               destroyed
);

  localparam int CNT_MAX = (RESPAWN_TICKS > FLASH_TICKS) ? RESPAWN_TICKS : FLASH_TICKS;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  state_t               r_state;
  logic [COORD_W-1:0]   r_ty;
  logic                 r_dir_up;
  logic [CNT_W-1:0]     r_cnt;
  logic [2:0]           r_hp;
  logic                 r_hit;
  logic                 r_target;

  logic [11:0]          w_ty;
  logic [11:0]          w_step;
  logic                 w_hit_ov;
  logic                 w_in_box;

  assign w_ty   = {1'b0, r_ty};
  assign w_step = 12'(STEP);

  // Bullet square against the target box.
  bullet_target_box_overlap #(
    .A_W (BW),
    .A_H (BW),
    .B_W (TW),
    .B_H (TH)
  ) u_hit_ov (
    .ax      ({1'b0, bx}),
    .ay      ({1'b0, by}),
    .bx      ({1'b0, TX}),
    .by      (w_ty),
    .overlap (w_hit_ov)
  );

  // Scan position as a 1x1 box against the target box gives in_box.
  bullet_target_box_overlap #(
    .A_W (1),
    .A_H (1),
    .B_W (TW),
    .B_H (TH)
  ) u_in_box (
    .ax      ({1'b0, x}),
    .ay      ({1'b0, y}),
    .bx      ({1'b0, TX}),
    .by      (w_ty),
    .overlap (w_in_box)
  );

  // Target state machine, patrol, hit points and registered pixel enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ALIVE;
      r_ty     <= Y_MIN;
      r_dir_up <= 1'b0;
      r_cnt    <= '0;
      r_hp     <= 3'(HP);
      r_hit    <= 1'b0;
      r_target <= 1'b0;
    end else begin
      r_hit    <= 1'b0;
      r_target <= w_in_box && ((r_state == ALIVE) || ((r_state == FLASH) && !r_cnt[0]));
      case (r_state)
        ALIVE: begin
          if (bvalid && w_hit_ov) begin
            // A hit takes priority over a coincident movement tick.
            r_hit   <= 1'b1;
            r_hp    <= r_hp - 3'd1;
            r_cnt   <= '0;
            r_state <= FLASH;
          end else if (timer) begin
            if (!r_dir_up) begin
              if (w_ty + w_step > {1'b0, Y_MAX}) begin
                r_ty     <= Y_MAX;
                r_dir_up <= 1'b1;
              end else begin
                r_ty <= r_ty + 11'(STEP);
              end
            end else begin
              if (w_ty < {1'b0, Y_MIN} + w_step) begin
                r_ty     <= Y_MIN;
                r_dir_up <= 1'b0;
              end else begin
                r_ty <= r_ty - 11'(STEP);
              end
            end
          end
        end
        FLASH: begin
          if (timer) begin
            if (r_cnt == CNT_W'(FLASH_TICKS - 1)) begin
              r_cnt   <= '0;
              r_state <= (r_hp == 3'd0) ? DEAD : ALIVE;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        DEAD: begin
          if (timer) begin
            if (r_cnt == CNT_W'(RESPAWN_TICKS - 1)) begin
              r_cnt    <= '0;
              r_state  <= ALIVE;
              r_hp     <= 3'(HP);
              r_ty     <= Y_MIN;
              r_dir_up <= 1'b0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        default: r_state <= ALIVE;
      endcase
    end
  end

  assign target    = r_target;
  assign hit       = r_hit;
  assign hp_left   = r_hp;
  assign destroyed = (r_state == DEAD);

endmodule
`default_nettype wire

// File: tb/tb_bullet_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_bullet_target
// Brief    : Scoreboard bench for bullet_target
// Revision : 1.0 - initial release
// ============================================================================
module tb_bullet_target;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] x = '0, y = '0, bx = '0, by = '0;
  logic        bvalid = 1'b0, timer = 1'b0;
  logic        target, hit, destroyed;
  logic [2:0]  hp_left;

  bullet_target dut (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .y         (y),
    .bx        (bx),
    .by        (by),
    .bvalid    (bvalid),
    .timer     (timer),
    .target    (target),
    .hit       (hit),
    .hp_left   (hp_left),
    .destroyed (destroyed)
  );

  always #5 clk = ~clk;

  localparam int K_HIT = 0, K_HP = 1, K_DEST = 2, K_TGT = 3, K_TY = 4;

  typedef struct {
    int    cyc;
    string name;
    int    kind;
    int    exp;
  } chk_t;

  chk_t chk_q[$];
  int   hit_q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic int actual(int k);
    case (k)
      K_HIT:   return int'(hit);
      K_HP:    return int'(hp_left);
      K_DEST:  return int'(destroyed);
      K_TGT:   return int'(target);
      default: return int'(dut.r_ty);
    endcase
  endfunction

  // Monitor: checks every hit pulse against expected hits, and drains due checks.
  initial forever begin
    @(negedge clk);
    if (hit === 1'b1) begin
      vectors++;
      if (hit_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_hit cyc=%0d got hit=1 required hit=0", cyc);
      end else begin
        int c;
        c = hit_q.pop_front();
        if (c != cyc) begin
          miscompares++;
          $display("FAIL hit_cycle got cyc=%0d required cyc=%0d", cyc, c);
        end
      end
    end
    while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
      chk_t e;
      int   a;
      e = chk_q.pop_front();
      a = actual(e.kind);
      vectors++;
      if (a != e.exp) begin
        miscompares++;
        $display("FAIL %s cyc=%0d got %0d required %0d", e.name, cyc, a, e.exp);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout got no finish required finish");
    $fatal(1, "timeout");
  end

  task automatic edge_();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(string n, int k, int v);
    chk_q.push_back('{cyc, n, k, v});
  endtask

  task automatic tick();
    timer = 1'b1;
    edge_();
    timer = 1'b0;
  endtask

  // Overlapping bullet at ty=40: bx 806..810 vs 800..816, by 50..54 vs 40..72.
  task automatic do_hit(int exp_hp, bit with_timer);
    bx = 11'd806; by = 11'd50; bvalid = 1'b1; timer = with_timer;
    edge_();
    bvalid = 1'b0; timer = 1'b0;
    hit_q.push_back(cyc);
    expect_v("hit_pulse", K_HIT, 1);
    expect_v("hp_after_hit", K_HP, exp_hp);
    expect_v("ty_frozen_on_hit", K_TY, 40);
  endtask

  task automatic flash_out();
    repeat (8) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    edge_();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    expect_v("rst_hit", K_HIT, 0);
    expect_v("rst_hp", K_HP, 3);
    expect_v("rst_destroyed", K_DEST, 0);
    expect_v("rst_target", K_TGT, 0);
    expect_v("rst_ty", K_TY, 40);

    // Patrol: ty = 40 + 2*i up to 440 at tick 200, clamps at 440, then descends
    for (int i = 1; i <= 200; i++) begin
      tick();
      expect_v("patrol_ty", K_TY, 40 + 2 * i);
    end
    tick();
    expect_v("patrol_turn_ty", K_TY, 440);
    tick();
    expect_v("patrol_up_ty", K_TY, 438);

    // Single hit at ty=40, then a second overlapping cycle in FLASH
    do_reset();
    expect_v("ty_after_rst", K_TY, 40);
    do_hit(2, 1'b0);
    bx = 11'd806; by = 11'd50; bvalid = 1'b1;
    x = 11'd805; y = 11'd45;
    edge_();
    bvalid = 1'b0;
    expect_v("flash_no_hit", K_HIT, 0);
    expect_v("flash_hp_hold", K_HP, 2);
    expect_v("flash_cnt0_visible", K_TGT, 1);
    tick();
    edge_();
    expect_v("flash_cnt1_hidden", K_TGT, 0);
    tick();
    edge_();
    expect_v("flash_cnt2_visible", K_TGT, 1);
    repeat (6) tick();
    expect_v("flash_done_dest", K_DEST, 0);
    expect_v("flash_done_hp", K_HP, 2);
    expect_v("flash_ty_frozen", K_TY, 40);

    // Edge misses and pixel box boundaries in ALIVE
    bx = 11'd796; by = 11'd50; bvalid = 1'b1;
    edge_();
    expect_v("miss_left_edge", K_HIT, 0);
    bx = 11'd806; by = 11'd72;
    edge_();
    expect_v("miss_bottom_edge", K_HIT, 0);
    bx = 11'd806; by = 11'd50; bvalid = 1'b0;
    edge_();
    expect_v("miss_bvalid_low", K_HIT, 0);
    expect_v("miss_hp_hold", K_HP, 2);
    x = 11'd805; y = 11'd45;
    edge_();
    expect_v("pix_alive_in", K_TGT, 1);
    x = 11'd816;
    edge_();
    expect_v("pix_right_out", K_TGT, 0);
    x = 11'd800; y = 11'd40;
    edge_();
    expect_v("pix_corner_in", K_TGT, 1);
    y = 11'd72;
    edge_();
    expect_v("pix_bottom_out", K_TGT, 0);
    x = 11'd799; y = 11'd45;
    edge_();
    expect_v("pix_left_out", K_TGT, 0);

    // Hit coinciding with timer: hit wins, ty stays at 40
    do_hit(1, 1'b1);
    flash_out();
    expect_v("post_flash2_dest", K_DEST, 0);

    // Kill and respawn
    do_hit(0, 1'b0);
    repeat (7) tick();
    expect_v("kill_7th_dest", K_DEST, 0);
    tick();
    expect_v("kill_8th_dest", K_DEST, 1);
    x = 11'd805; y = 11'd45;
    edge_();
    expect_v("dead_pix_hidden", K_TGT, 0);
    repeat (59) tick();
    expect_v("dead_59_dest", K_DEST, 1);
    tick();
    expect_v("respawn_dest", K_DEST, 0);
    expect_v("respawn_hp", K_HP, 3);
    expect_v("respawn_ty", K_TY, 40);
    edge_();
    expect_v("respawn_pix", K_TGT, 1);

    // Reset in the middle of DEAD
    do_hit(2, 1'b0); flash_out();
    do_hit(1, 1'b0); flash_out();
    do_hit(0, 1'b0); flash_out();
    repeat (10) tick();
    expect_v("dead_again_dest", K_DEST, 1);
    do_reset();
    expect_v("rst_dead_dest", K_DEST, 0);
    expect_v("rst_dead_hp", K_HP, 3);
    expect_v("rst_dead_ty", K_TY, 40);
    expect_v("rst_dead_tgt", K_TGT, 0);
    edge_();
    expect_v("rst_dead_pix_alive", K_TGT, 1);

    // Drain and finish
    repeat (3) edge_();
    if (chk_q.size() != 0) begin
      miscompares++;
      $display("FAIL undrained_checks got %0d pending required 0", chk_q.size());
    end
    if (hit_q.size() != 0) begin
      miscompares++;
      $display("FAIL missing_hits got %0d pending required 0", hit_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bullet_target.md
Name: bullet_target

Overview:
- Receiving end of the bullet path in the VGA shooter.
- Owns one target sprite that patrols vertically at a fixed column and takes bullet position/valid from the bullet block.
- Detects collisions, tracks hit points, flashes, dies and respawns.
- Drives a registered pixel-enable for the VGA mux, plus a one-cycle hit pulse that the bullet logic uses to retire the bullet and the score logic uses to count.

Parameters:
- TX, 11'd800: target left x (pixels)
- TW, 16: target width
- TH, 32: target height
- BW, 4: bullet square size
- Y_MIN, 11'd40: top patrol limit
- Y_MAX, 11'd440: bottom patrol limit (max ty)
- STEP, 2: pixels moved per timer tick
- HP, 3: hit points, 1..7
- FLASH_TICKS, 8: timer ticks spent in FLASH
- RESPAWN_TICKS, 60: timer ticks spent in DEAD

Ports:
- clk, in, 1: system clock
- rst, in, 1: synchronous active-high reset
- x, in, 11: current VGA scan x
- y, in, 11: current VGA scan y
- bx, in, 11: bullet top-left x
- by, in, 11: bullet top-left y
- bvalid, in, 1: bullet currently in flight
- timer, in, 1: one-cycle movement tick
- target, out, 1: pixel enable (registered)
- hit, out, 1: one-cycle collision pulse
- hp_left, out, 3: remaining hit points
- destroyed, out, 1: high while in DEAD

Behaviour:
- Everything is on posedge clk.
- When rst=1 on an edge, the block resets to:
  - state=ALIVE, ty=Y_MIN, dir=down, hp_left=HP
  - tick counter=0, target=0, hit=0, destroyed=0
- All coordinate sums are computed at 12 bits so there is no wrap.
- Overlap is true when all of the following hold (half-open boxes):
  - bx < TX+TW and bx+BW > TX
  - by < ty+TH and by+BW > ty
- State ALIVE:
  - On timer, move ty by STEP in direction dir.
  - Moving down: if ty+STEP > Y_MAX, then ty <= Y_MAX and dir <= up.
  - Moving up: if ty < Y_MIN+STEP, then ty <= Y_MIN and dir <= down.
  - If bvalid and overlap: hit <= 1 for exactly one cycle, hp_left decrements, cnt <= 0, and the next state is FLASH.
  - If a hit and a timer tick arrive in the same cycle, the hit wins and ty does not move that cycle.
- State FLASH:
  - Invulnerable: no hit pulse, collisions are ignored.
  - ty is frozen.
  - cnt increments on each timer tick.
  - When cnt reaches FLASH_TICKS-1 and a timer tick arrives: cnt <= 0; go to DEAD if hp_left==0, otherwise back to ALIVE.
- State DEAD:
  - destroyed=1, sprite hidden.
  - cnt increments on each timer tick.
  - When cnt reaches RESPAWN_TICKS-1 and a timer tick arrives: go to ALIVE with hp_left=HP, ty=Y_MIN, dir=down, cnt=0.
- Pixel output:
  - target <= in_box(x,y) && (ALIVE || (FLASH && cnt[0]==0)).
  - in_box is TX ≤ x < TX+TW and ty ≤ y < ty+TH.
  - The output lags x/y by one cycle, matching the other sprites.
- If bvalid drops in the same cycle the overlap becomes true, there is no hit (bvalid is sampled that cycle).
- A bullet that keeps overlapping after a hit cannot hit again until FLASH has ended. The bullet block must retire it on hit.
- rst asserted mid-FLASH or mid-DEAD returns the block to the full reset state on the next edge.
- hp_left never underflows: a hit only happens in ALIVE, and hp_left is ≥1 there.

Decomposition:
- Shared game package holds:
  - screen constants: H_ACTIVE=1024, V_ACTIVE=768
  - the coordinate width constant (11)
  - the state encoding: ALIVE=2'd0, FLASH=2'd1, DEAD=2'd2
- One natural sub-module: box_overlap. It is a combinational 12-bit AABB test with parameterised sizes, reused here for both the collision test and the pixel in_box test.

Test Plan:
1. Patrol bounce:
   - Stimulus: reset, then 200 timer ticks with bvalid=0.
   - Required: ty runs 40,42,…,440, then turns and reaches 440 after tick 200. ty never leaves [40,440].
2. Single hit:
   - Stimulus: ty=40; bx=806, by=50, bvalid=1 for 1 cycle.
   - Required: hit=1 for 1 cycle, hp_left 3→2, state FLASH.
   - Required: a second overlapping cycle during FLASH gives no hit.
3. Edge miss:
   - Stimulus: bx=796 (bx+BW=800, touching but not overlapping), and separately by=72 with ty=40.
   - Required: hit stays 0 in both cases.
4. Kill and respawn:
   - Stimulus: 3 hits, each after its FLASH ends.
   - Required: destroyed=1 after the 8th timer tick of the final FLASH.
   - Required: after 60 more ticks, destroyed=0, hp_left=3, ty=40.
5. Hit versus timer collision:
   - Stimulus: overlap and timer in the same cycle.
   - Required: hit=1 and ty unchanged.
6. Pixel and flash:
   - Stimulus: scan x=805, y=ty+5.
   - Required: target=1 one cycle later in ALIVE. In FLASH, target alternates per tick (visible on even cnt). In DEAD, target=0.
   - Stimulus: rst mid-DEAD.
   - Required: ALIVE, hp_left=3 on the next edge.
